// File: rtl/warp_scheduler_if.sv
// Issue channel between the warp scheduler and the execute stage.
// The instruction sits in the issue register while issue_valid is high. It is transferred on
// any rising edge with issue_valid & exec_ready. While valid and not ready, every field holds.
interface warp_scheduler_if #(
  parameter int WW = 2,
  parameter int RW = 4
);
  logic          issue_valid;
  logic [WW-1:0] issue_warp;
  logic [3:0]    issue_opcode;
  logic [RW-1:0] issue_target;
  logic [RW-1:0] issue_address;
  logic          exec_ready;

  modport master (
    output issue_valid, issue_warp, issue_opcode, issue_target, issue_address,
    input  exec_ready
  );

  modport slave (
    input  issue_valid, issue_warp, issue_opcode, issue_target, issue_address,
    output exec_ready
  );
endinterface

// File: rtl/warp_scheduler.sv
// Round-robin per-warp issue scheduler with a per-warp register scoreboard.
// It tracks filled instruction slots, picks one hazard-free warp per cycle and requests a refill of that slot.
module warp_scheduler #(
  parameter int NUM_WARPS = 4,
  parameter int NUM_REGS  = 16,
  parameter int WW        = $clog2(NUM_WARPS),
  parameter int RW        = $clog2(NUM_REGS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          buf_write_en,
  input  logic [WW-1:0]                 warp_num_store,
  input  logic [NUM_WARPS-1:0]          warp_active,
  input  logic [NUM_WARPS-1:0][3:0]     opcode_in,
  input  logic [NUM_WARPS-1:0][RW-1:0]  target_reg_in,
  input  logic [NUM_WARPS-1:0][RW-1:0]  address_reg_in,
  input  logic                          wb_valid,
  input  logic [WW-1:0]                 wb_warp,
  input  logic [RW-1:0]                 wb_reg,
  warp_scheduler_if.master              iss,
  output logic                          fetch_req,
  output logic [WW-1:0]                 fetch_warp,
  output logic [NUM_WARPS-1:0]          slot_full
);

  logic [NUM_WARPS-1:0][NUM_REGS-1:0] sb;
  logic [NUM_WARPS-1:0]               eligible;
  logic [WW-1:0]                      rr_ptr;
  logic [WW-1:0]                      grant_warp;
  logic [WW-1:0]                      probe;
  logic                               grant_valid;
  logic                               can_load;
  logic                               load;

  // NOPs bypass the hazard check: they neither read nor write a register.
  always_comb begin
    eligible = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      eligible[w] = warp_active[w] & slot_full[w] &
                    ((opcode_in[w] == 4'h0) |
                     (!sb[w][address_reg_in[w]] & !sb[w][target_reg_in[w]]));
    end
  end

  // The search wraps by the natural overflow of the WW-bit index, so NUM_WARPS must be a power of two.
  always_comb begin
    grant_valid = 1'b0;
    grant_warp  = '0;
    probe       = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      probe = rr_ptr + WW'(i);
      if (!grant_valid && eligible[probe]) begin
        grant_valid = 1'b1;
        grant_warp  = probe;
      end
    end
  end

  assign can_load = !iss.issue_valid | iss.exec_ready;
  assign load     = can_load & grant_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iss.issue_valid   <= 1'b0;
      iss.issue_warp    <= '0;
      iss.issue_opcode  <= '0;
      iss.issue_target  <= '0;
      iss.issue_address <= '0;
      fetch_req         <= 1'b0;
      fetch_warp        <= '0;
      rr_ptr            <= '0;
    end else begin
      fetch_req <= load;
      if (load) begin
        iss.issue_valid   <= 1'b1;
        iss.issue_warp    <= grant_warp;
        iss.issue_opcode  <= opcode_in[grant_warp];
        iss.issue_target  <= target_reg_in[grant_warp];
        iss.issue_address <= address_reg_in[grant_warp];
        fetch_warp        <= grant_warp;
        rr_ptr            <= grant_warp + WW'(1);
      end else if (iss.issue_valid && iss.exec_ready) begin
        iss.issue_valid <= 1'b0;
      end
    end
  end

  // A buffer write beats a same-cycle grant so the freshly stored instruction is not lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_full <= '0;
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (buf_write_en && (warp_num_store == WW'(w)))
          slot_full[w] <= 1'b1;
        else if (load && (grant_warp == WW'(w)))
          slot_full[w] <= 1'b0;
      end
    end
  end

  // The set is written after the clear so it wins on a same-bit collision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sb <= '0;
    end else begin
      if (wb_valid)
        sb[wb_warp][wb_reg] <= 1'b0;
      if (load && (opcode_in[grant_warp] != 4'h0))
        sb[grant_warp][target_reg_in[grant_warp]] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_warp_scheduler.sv
// Directed bench for warp_scheduler: hand-computed issue order, hazard stalls, backpressure,
// write/grant collision, inactive warps and asynchronous reset.
module tb_warp_scheduler;

  logic             clk;
  logic             reset;
  logic             buf_write_en;
  logic [1:0]       warp_num_store;
  logic [3:0]       warp_active;
  logic [3:0][3:0]  opcode_in;
  logic [3:0][3:0]  target_reg_in;
  logic [3:0][3:0]  address_reg_in;
  logic             wb_valid;
  logic [1:0]       wb_warp;
  logic [3:0]       wb_reg;
  logic             fetch_req;
  logic [1:0]       fetch_warp;
  logic [3:0]       slot_full;

  int total = 0;
  int bad   = 0;

  warp_scheduler_if #(.WW(2), .RW(4)) iss ();

  warp_scheduler dut (
    .clk            (clk),
    .reset          (reset),
    .buf_write_en   (buf_write_en),
    .warp_num_store (warp_num_store),
    .warp_active    (warp_active),
    .opcode_in      (opcode_in),
    .target_reg_in  (target_reg_in),
    .address_reg_in (address_reg_in),
    .wb_valid       (wb_valid),
    .wb_warp        (wb_warp),
    .wb_reg         (wb_reg),
    .iss            (iss),
    .fetch_req      (fetch_req),
    .fetch_warp     (fetch_warp),
    .slot_full      (slot_full)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int w, input logic [3:0] op, input logic [3:0] tgt,
                          input logic [3:0] adr);
    opcode_in[w]      = op;
    target_reg_in[w]  = tgt;
    address_reg_in[w] = adr;
  endtask

  task automatic write_en(input logic en, input logic [1:0] w);
    buf_write_en   = en;
    warp_num_store = w;
  endtask

  task automatic check_issue(input string tag, input logic v, input logic [1:0] w,
                             input logic [3:0] op, input logic [3:0] tgt, input logic [3:0] adr);
    check({tag, ".valid"}, 32'(iss.issue_valid), 32'(v));
    if (v) begin
      check({tag, ".warp"}, 32'(iss.issue_warp), 32'(w));
      check({tag, ".op"},   32'(iss.issue_opcode), 32'(op));
      check({tag, ".tgt"},  32'(iss.issue_target), 32'(tgt));
      check({tag, ".adr"},  32'(iss.issue_address), 32'(adr));
    end
  endtask

  task automatic check_fetch(input string tag, input logic req, input logic [1:0] w);
    check({tag, ".freq"}, 32'(fetch_req), 32'(req));
    if (req) check({tag, ".fwarp"}, 32'(fetch_warp), 32'(w));
  endtask

  initial begin
    reset          = 1'b0;
    buf_write_en   = 1'b0;
    warp_num_store = 2'd0;
    warp_active    = 4'hF;
    opcode_in      = '0;
    target_reg_in  = '0;
    address_reg_in = '0;
    wb_valid       = 1'b0;
    wb_warp        = 2'd0;
    wb_reg         = 4'd0;
    iss.exec_ready = 1'b1;

    #2 reset = 1'b1;
    #1;
    check("rst.valid", 32'(iss.issue_valid), 32'd0);
    check("rst.warp",  32'(iss.issue_warp), 32'd0);
    check("rst.op",    32'(iss.issue_opcode), 32'd0);
    check("rst.freq",  32'(fetch_req), 32'd0);
    check("rst.fwarp", 32'(fetch_warp), 32'd0);
    check("rst.slot",  32'(slot_full), 32'd0);
    tick();
    #3 reset = 1'b0;

    // burst of NOPs to warps 0..3: issues 0,1,2,3 on consecutive cycles
    for (int w = 0; w < 4; w++) begin
      write_en(1'b1, 2'(w));
      tick();
      if (w == 0) begin
        check_issue("burst0", 1'b0, 2'd0, 4'h0, 4'h0, 4'h0);
        check("burst0.slot", 32'(slot_full), 32'h1);
      end else begin
        check_issue($sformatf("burst%0d", w), 1'b1, 2'(w - 1), 4'h0, 4'h0, 4'h0);
        check_fetch($sformatf("burst%0d", w), 1'b1, 2'(w - 1));
        check($sformatf("burst%0d.slot", w), 32'(slot_full), 32'(4'b0001 << w));
      end
    end
    write_en(1'b0, 2'd0);
    tick();
    check_issue("burst4", 1'b1, 2'd3, 4'h0, 4'h0, 4'h0);
    check_fetch("burst4", 1'b1, 2'd3);
    check("burst4.slot", 32'(slot_full), 32'h0);
    tick();
    check_issue("burst5", 1'b0, 2'd0, 4'h0, 4'h0, 4'h0);
    check_fetch("burst5", 1'b0, 2'd0);

    // RAW hazard on warp 1, R5 (rr_ptr = 0)
    set_slot(1, 4'h3, 4'd5, 4'd0);
    write_en(1'b1, 2'd1);
    tick();
    write_en(1'b0, 2'd0);
    check("raw.slot", 32'(slot_full), 32'h2);
    tick();
    check_issue("raw.first", 1'b1, 2'd1, 4'h3, 4'd5, 4'd0);
    set_slot(1, 4'h4, 4'd6, 4'd5);
    write_en(1'b1, 2'd1);
    tick();
    write_en(1'b0, 2'd0);
    check_issue("raw.blk0", 1'b0, 2'd0, 4'h0, 4'h0, 4'h0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check_issue($sformatf("raw.blk%0d", i + 1), 1'b0, 2'd0, 4'h0, 4'h0, 4'h0);
      check($sformatf("raw.slot%0d", i + 1), 32'(slot_full), 32'h2);
    end
    wb_valid = 1'b1;
    wb_warp  = 2'd1;
    wb_reg   = 4'd5;
    tick();
    wb_valid = 1'b0;
    check_issue("raw.wb_n1", 1'b0, 2'd0, 4'h0, 4'h0, 4'h0);
    tick();
    check_issue("raw.wb_n2", 1'b1, 2'd1, 4'h4, 4'd6, 4'd5);
    check_fetch("raw.wb_n2", 1'b1, 2'd1);
    tick();

    // backpressure on warp 2 with warps 0 and 3 full (rr_ptr = 2)
    set_slot(1, 4'h0, 4'd0, 4'd0);
    write_en(1'b1, 2'd2);
    tick();
    iss.exec_ready = 1'b0;
    write_en(1'b1, 2'd0);
    tick();
    check_issue("bp.issue2", 1'b1, 2'd2, 4'h0, 4'h0, 4'h0);
    write_en(1'b1, 2'd3);
    tick();
    write_en(1'b0, 2'd0);
    check_issue("bp.hold0", 1'b1, 2'd2, 4'h0, 4'h0, 4'h0);
    check_fetch("bp.hold0", 1'b0, 2'd0);
    check("bp.slot0", 32'(slot_full), 32'h9);
    tick();
    check_issue("bp.hold1", 1'b1, 2'd2, 4'h0, 4'h0, 4'h0);
    check_fetch("bp.hold1", 1'b0, 2'd0);
    check("bp.slot1", 32'(slot_full), 32'h9);
    iss.exec_ready = 1'b1;
    tick();
    check_issue("bp.next3", 1'b1, 2'd3, 4'h0, 4'h0, 4'h0);
    check_fetch("bp.next3", 1'b1, 2'd3);
    check("bp.slot2", 32'(slot_full), 32'h1);
    tick();
    check_issue("bp.next0", 1'b1, 2'd0, 4'h0, 4'h0, 4'h0);
    check("bp.slot3", 32'(slot_full), 32'h0);
    tick();
    check_issue("bp.idle", 1'b0, 2'd0, 4'h0, 4'h0, 4'h0);

    // write and grant collide on warp 0 (rr_ptr = 1)
    write_en(1'b1, 2'd0);
    tick();
    check("col.slot0", 32'(slot_full), 32'h1);
    tick();
    write_en(1'b0, 2'd0);
    check_issue("col.first", 1'b1, 2'd0, 4'h0, 4'h0, 4'h0);
    check("col.slot1", 32'(slot_full), 32'h1);
    set_slot(0, 4'h5, 4'd9, 4'd1);
    tick();
    check_issue("col.second", 1'b1, 2'd0, 4'h5, 4'd9, 4'd1);
    check_fetch("col.second", 1'b1, 2'd0);
    check("col.slot2", 32'(slot_full), 32'h0);
    tick();

    // inactive warp 2 never issues (rr_ptr = 1)
    set_slot(0, 4'h0, 4'd0, 4'd0);
    warp_active = 4'b0000;
    for (int w = 0; w < 4; w++) begin
      write_en(1'b1, 2'(w));
      tick();
    end
    write_en(1'b0, 2'd0);
    check("act.slot_all", 32'(slot_full), 32'hF);
    check_issue("act.none", 1'b0, 2'd0, 4'h0, 4'h0, 4'h0);
    warp_active = 4'b1011;
    tick();
    check_issue("act.g1", 1'b1, 2'd1, 4'h0, 4'h0, 4'h0);
    tick();
    check_issue("act.g3", 1'b1, 2'd3, 4'h0, 4'h0, 4'h0);
    tick();
    check_issue("act.g0", 1'b1, 2'd0, 4'h0, 4'h0, 4'h0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check_issue($sformatf("act.idle%0d", i), 1'b0, 2'd0, 4'h0, 4'h0, 4'h0);
      check($sformatf("act.slot%0d", i), 32'(slot_full), 32'h4);
    end

    // async reset mid-handshake with sb[0][7] set
    set_slot(0, 4'h2, 4'd7, 4'd0);
    write_en(1'b1, 2'd0);
    tick();
    write_en(1'b0, 2'd0);
    iss.exec_ready = 1'b0;
    tick();
    check_issue("ar.held", 1'b1, 2'd0, 4'h2, 4'd7, 4'd0);
    #2 reset = 1'b1;
    #1;
    check("ar.valid", 32'(iss.issue_valid), 32'd0);
    check("ar.slot",  32'(slot_full), 32'h0);
    check("ar.freq",  32'(fetch_req), 32'd0);
    #2 reset = 1'b0;
    iss.exec_ready = 1'b1;
    warp_active    = 4'hF;
    // reading R7 would stall if the scoreboard survived reset
    set_slot(0, 4'h2, 4'd8, 4'd7);
    tick();
    write_en(1'b1, 2'd0);
    tick();
    write_en(1'b0, 2'd0);
    tick();
    check_issue("ar.sb_clear", 1'b1, 2'd0, 4'h2, 4'd8, 4'd7);
    tick();

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
